// File: rtl/note_event_fifo_if.sv
// Purpose : bundles the event-capture inputs and the read/status outputs of
//           note_event_fifo into one interface.
// Modports: master - event producer / reader side (drives note, note_dur,
//                    new_note, note_dec, rd_en, clr_ovf)
//           slave  - the FIFO (drives rd_data, rd_valid, empty, full,
//                    count, overflow, drop_cnt, idle_frames)
interface note_event_fifo_if #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [7:0]       note;
    logic [3:0]       note_dur;
    logic             new_note;
    logic             note_dec;
    logic             rd_en;
    logic             clr_ovf;
    logic [15:0]      rd_data;
    logic             rd_valid;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] idle_frames;

    modport master (
        output note, note_dur, new_note, note_dec, rd_en, clr_ovf,
        input  rd_data, rd_valid, empty, full, count, overflow, drop_cnt, idle_frames
    );

    modport slave (
        input  note, note_dur, new_note, note_dec, rd_en, clr_ovf,
        output rd_data, rd_valid, empty, full, count, overflow, drop_cnt, idle_frames
    );
endinterface

// File: rtl/note_event_fifo.sv
// Purpose : captures note events from fft_ctrl (rising edge of new_note),
//           tags them with a 4-bit sequence number and queues them in a
//           DEPTH-entry FIFO drained by a registered read handshake. Also
//           tracks dropped events and frames since the last stored event.
// Ports   : clk_in - system clock
//           reset  - synchronous, active-high reset
//           bus    - note_event_fifo_if.slave (event inputs, read port, status)
module note_event_fifo #(
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned KEEP_RESTS = 1,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk_in,
    input  logic             reset,
    note_event_fifo_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [15:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [3:0]       r_seq;
    logic             r_new_note_q;
    logic             r_note_dec_q;
    logic [15:0]      r_rd_data;
    logic             r_rd_valid;
    logic             r_empty;
    logic             r_full;
    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] r_idle_frames;

    logic             w_ev;
    logic             w_fr;
    logic             w_pass;
    logic             w_rd_accept;
    logic             w_wr;
    logic             w_drop;
    logic [CW-1:0]    w_count_nxt;

    // Event/frame edge detect, rest filter and read/write/drop decisions
    always_comb begin
        w_ev        = bus.new_note & ~r_new_note_q;
        w_fr        = bus.note_dec & ~r_note_dec_q;
        w_pass      = (KEEP_RESTS != 0) || (bus.note != 8'd0);
        w_rd_accept = bus.rd_en && (r_count != CW'(0));
        // A read in the same cycle frees a slot, so a full FIFO still accepts
        w_wr        = w_ev && w_pass && ((r_count != CW'(DEPTH)) || w_rd_accept);
        w_drop      = w_ev && w_pass && !w_wr;
        w_count_nxt = r_count;
        if (w_wr && !w_rd_accept) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_wr && w_rd_accept) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Storage array; intentionally not reset
    always_ff @(posedge clk_in) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {bus.note, bus.note_dur, r_seq};
        end
    end

    // Control, status and read-port registers
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_seq         <= '0;
            r_new_note_q  <= 1'b0;
            r_note_dec_q  <= 1'b0;
            r_rd_data     <= '0;
            r_rd_valid    <= 1'b0;
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_overflow    <= 1'b0;
            r_drop_cnt    <= '0;
            r_idle_frames <= '0;
        end else begin
            r_new_note_q <= bus.new_note;
            r_note_dec_q <= bus.note_dec;
            r_count      <= w_count_nxt;
            r_empty      <= (w_count_nxt == CW'(0));
            r_full       <= (w_count_nxt == CW'(DEPTH));
            r_rd_valid   <= w_rd_accept;

            if (w_rd_accept) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + AW'(1);
            end

            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_seq    <= r_seq + 4'd1;
            end

            // A drop in the same cycle as clr_ovf wins and restarts the count at 1
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (bus.clr_ovf) begin
                    r_drop_cnt <= CNT_W'(1);
                end else if (r_drop_cnt != {CNT_W{1'b1}}) begin
                    r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                end
            end else if (bus.clr_ovf) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= '0;
            end

            if (w_wr) begin
                r_idle_frames <= '0;
            end else if (w_fr && (r_idle_frames != {CNT_W{1'b1}})) begin
                r_idle_frames <= r_idle_frames + CNT_W'(1);
            end
        end
    end

    assign bus.rd_data     = r_rd_data;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.empty       = r_empty;
    assign bus.full        = r_full;
    assign bus.count       = r_count;
    assign bus.overflow    = r_overflow;
    assign bus.drop_cnt    = r_drop_cnt;
    assign bus.idle_frames = r_idle_frames;
endmodule

// File: tb/tb_note_event_fifo.sv
// Purpose : self-checking bench for note_event_fifo. A queue-based reference
//           model tracks every cycle; directed vectors and sequences add
//           fixed expected values for the documented corner cases.
module tb_note_event_fifo;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned CNT_W = 8;
    localparam int          SAT   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic rst0;

    always #5 clk = ~clk;

    note_event_fifo_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
    note_event_fifo_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus0 ();

    note_event_fifo #(.DEPTH(DEPTH), .KEEP_RESTS(1), .CNT_W(CNT_W)) dut (
        .clk_in (clk),
        .reset  (rst),
        .bus    (bus)
    );

    note_event_fifo #(.DEPTH(DEPTH), .KEEP_RESTS(0), .CNT_W(CNT_W)) dut0 (
        .clk_in (clk),
        .reset  (rst0),
        .bus    (bus0)
    );

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model state
    logic [15:0] q[$];
    logic [3:0]  m_seq;
    logic        m_nn_q, m_nd_q;
    logic [15:0] m_rd_data;
    logic        m_rd_valid;
    logic        m_ovf;
    int          m_drop;
    int          m_idle;

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Advance the model by one clock using the inputs currently driven,
    // clock the DUT, then compare every output.
    task automatic step();
        logic ev, fr, rd_acc, wr, drop;
        if (rst) begin
            q.delete();
            m_seq = 4'd0; m_nn_q = 1'b0; m_nd_q = 1'b0;
            m_rd_data = 16'd0; m_rd_valid = 1'b0;
            m_ovf = 1'b0; m_drop = 0; m_idle = 0;
        end else begin
            ev     = bus.new_note && !m_nn_q;
            fr     = bus.note_dec && !m_nd_q;
            m_nn_q = bus.new_note;
            m_nd_q = bus.note_dec;
            rd_acc = bus.rd_en && (q.size() != 0);
            wr     = ev && ((q.size() < DEPTH) || rd_acc);
            drop   = ev && !wr;
            m_rd_valid = rd_acc;
            if (rd_acc) m_rd_data = q.pop_front();
            if (wr) begin
                q.push_back({bus.note, bus.note_dur, m_seq});
                m_seq = m_seq + 4'd1;
            end
            if (drop) begin
                m_ovf  = 1'b1;
                m_drop = bus.clr_ovf ? 1 : ((m_drop == SAT) ? SAT : m_drop + 1);
            end else if (bus.clr_ovf) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end
            if (wr) m_idle = 0;
            else if (fr && m_idle != SAT) m_idle = m_idle + 1;
        end
        @(posedge clk);
        #1;
        chk("model_rd_valid", int'(bus.rd_valid), int'(m_rd_valid));
        chk("model_rd_data", int'(bus.rd_data), int'(m_rd_data));
        chk("model_count", int'(bus.count), q.size());
        chk("model_empty", int'(bus.empty), int'(q.size() == 0));
        chk("model_full", int'(bus.full), int'(q.size() == DEPTH));
        chk("model_overflow", int'(bus.overflow), int'(m_ovf));
        chk("model_drop_cnt", int'(bus.drop_cnt), m_drop);
        chk("model_idle_frames", int'(bus.idle_frames), m_idle);
    endtask

    task automatic pulse_event(input logic [7:0] n, input logic [3:0] d);
        bus.note = n; bus.note_dur = d; bus.new_note = 1'b1;
        step();
        bus.new_note = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        nn;
        logic [7:0]  note;
        logic [3:0]  dur;
        logic        rd;
        int          exp_count;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic        exp_empty;
    } vec_t;

    vec_t vt[10];

    initial begin
        vt[0] = '{1'b1, 8'd40, 4'b0100, 1'b0, 1, 1'b0, 16'h0000, 1'b0};
        vt[1] = '{1'b0, 8'd40, 4'b0100, 1'b0, 1, 1'b0, 16'h0000, 1'b0};
        vt[2] = '{1'b1, 8'd42, 4'b0010, 1'b0, 2, 1'b0, 16'h0000, 1'b0};
        vt[3] = '{1'b0, 8'd42, 4'b0010, 1'b0, 2, 1'b0, 16'h0000, 1'b0};
        vt[4] = '{1'b1, 8'd44, 4'b1000, 1'b0, 3, 1'b0, 16'h0000, 1'b0};
        vt[5] = '{1'b0, 8'd44, 4'b1000, 1'b0, 3, 1'b0, 16'h0000, 1'b0};
        vt[6] = '{1'b0, 8'd0,  4'b0000, 1'b1, 2, 1'b1, 16'h2840, 1'b0};
        vt[7] = '{1'b0, 8'd0,  4'b0000, 1'b1, 1, 1'b1, 16'h2A21, 1'b0};
        vt[8] = '{1'b0, 8'd0,  4'b0000, 1'b1, 0, 1'b1, 16'h2C82, 1'b1};
        vt[9] = '{1'b0, 8'd0,  4'b0000, 1'b1, 0, 1'b0, 16'h2C82, 1'b1};

        bus.note = 8'd0; bus.note_dur = 4'd0; bus.new_note = 1'b0;
        bus.note_dec = 1'b0; bus.rd_en = 1'b0; bus.clr_ovf = 1'b0;
        bus0.note = 8'd0; bus0.note_dur = 4'd0; bus0.new_note = 1'b0;
        bus0.note_dec = 1'b0; bus0.rd_en = 1'b0; bus0.clr_ovf = 1'b0;
        rst = 1'b1; rst0 = 1'b1;
        step();
        step();

        // Reset state
        chk("reset_rd_data", int'(bus.rd_data), 0);
        chk("reset_rd_valid", int'(bus.rd_valid), 0);
        chk("reset_empty", int'(bus.empty), 1);
        chk("reset_full", int'(bus.full), 0);
        chk("reset_count", int'(bus.count), 0);
        chk("reset_overflow", int'(bus.overflow), 0);
        chk("reset_drop_cnt", int'(bus.drop_cnt), 0);
        chk("reset_idle", int'(bus.idle_frames), 0);
        rst = 1'b0; rst0 = 1'b0;

        // Rest filter on the KEEP_RESTS=0 instance
        bus0.note = 8'd0; bus0.new_note = 1'b1;
        step();
        bus0.new_note = 1'b0;
        step();
        chk("kr0_rest_count", int'(bus0.count), 0);
        chk("kr0_rest_drop", int'(bus0.drop_cnt), 0);
        bus0.note = 8'd7; bus0.new_note = 1'b1;
        step();
        bus0.new_note = 1'b0;
        step();
        chk("kr0_note_count", int'(bus0.count), 1);

        // Directed vector table: three events then three reads and one on empty
        for (int i = 0; i < 10; i++) begin
            bus.new_note = vt[i].nn; bus.note = vt[i].note;
            bus.note_dur = vt[i].dur; bus.rd_en = vt[i].rd;
            step();
            chk($sformatf("vec%0d_count", i), int'(bus.count), vt[i].exp_count);
            chk($sformatf("vec%0d_valid", i), int'(bus.rd_valid), int'(vt[i].exp_valid));
            chk($sformatf("vec%0d_data", i), int'(bus.rd_data), int'(vt[i].exp_data));
            chk($sformatf("vec%0d_empty", i), int'(bus.empty), int'(vt[i].exp_empty));
        end
        bus.rd_en = 1'b0;

        // new_note held high for 10 cycles is one event
        do_reset();
        bus.note = 8'd50; bus.note_dur = 4'd3; bus.new_note = 1'b1;
        for (int i = 0; i < 10; i++) step();
        bus.new_note = 1'b0;
        step();
        chk("held_count", int'(bus.count), 1);
        pulse_event(8'd51, 4'd1);
        bus.rd_en = 1'b1;
        step();
        chk("held_first", int'(bus.rd_data), 16'h3230);
        step();
        chk("held_next_seq", int'(bus.rd_data[3:0]), 1);
        bus.rd_en = 1'b0;
        step();

        // Fill, overflow by 3, drain in order with seq wrap, clear overflow
        do_reset();
        for (int i = 0; i < 35; i++) pulse_event(8'(i + 1), 4'(i));
        chk("fill_full", int'(bus.full), 1);
        chk("fill_overflow", int'(bus.overflow), 1);
        chk("fill_drop_cnt", int'(bus.drop_cnt), 3);
        bus.rd_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            chk($sformatf("drain%0d", i), int'(bus.rd_data), int'({8'(i + 1), 4'(i), 4'(i)}));
        end
        bus.rd_en = 1'b0;
        step();
        chk("drain_empty", int'(bus.empty), 1);
        bus.clr_ovf = 1'b1;
        step();
        bus.clr_ovf = 1'b0;
        chk("clr_overflow", int'(bus.overflow), 0);
        chk("clr_drop_cnt", int'(bus.drop_cnt), 0);

        // Full FIFO: write and read in the same cycle both succeed
        for (int i = 0; i < 32; i++) pulse_event(8'(100 + i), 4'd5);
        chk("refill_full", int'(bus.full), 1);
        bus.note = 8'd99; bus.note_dur = 4'd9; bus.new_note = 1'b1; bus.rd_en = 1'b1;
        step();
        bus.new_note = 1'b0; bus.rd_en = 1'b0;
        chk("simul_count", int'(bus.count), 32);
        chk("simul_overflow", int'(bus.overflow), 0);
        chk("simul_rd_data", int'(bus.rd_data), int'({8'd100, 4'd5, 4'd0}));
        step();

        // Rest event kept when KEEP_RESTS=1
        do_reset();
        pulse_event(8'd0, 4'd6);
        chk("kr1_rest_count", int'(bus.count), 1);
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        chk("kr1_rest_note", int'(bus.rd_data[15:8]), 0);

        // idle_frames: count, clear on write, saturate
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.note_dec = 1'b1; step();
            bus.note_dec = 1'b0; step();
        end
        chk("idle_5", int'(bus.idle_frames), 5);
        pulse_event(8'd60, 4'd2);
        chk("idle_clear", int'(bus.idle_frames), 0);
        for (int i = 0; i < 300; i++) begin
            bus.note_dec = 1'b1; step();
            bus.note_dec = 1'b0; step();
        end
        chk("idle_sat", int'(bus.idle_frames), SAT);

        // Reset asserted together with a read request: no pulse follows
        bus.rd_en = 1'b1; rst = 1'b1;
        step();
        chk("rstrd_valid", int'(bus.rd_valid), 0);
        chk("rstrd_empty", int'(bus.empty), 1);
        rst = 1'b0; bus.rd_en = 1'b0;
        step();
        chk("rstrd_after", int'(bus.rd_valid), 0);

        // Randomized traffic: fill-heavy phase, then drain-heavy phase
        for (int i = 0; i < 3000; i++) begin
            bus.new_note = 1'($urandom % 2);
            bus.note     = ($urandom % 4 == 0) ? 8'd0 : 8'($urandom);
            bus.note_dur = 4'($urandom);
            bus.note_dec = 1'($urandom % 2);
            bus.rd_en    = (i < 1500) ? ($urandom % 8 == 0) : ($urandom % 2 == 0);
            bus.clr_ovf  = ($urandom % 40 == 0);
            rst          = ($urandom % 700 == 0);
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
